// File: rtl/sector_dump_pkg.sv
// Shared types and helpers for the sector hex-dump formatter.
package sector_dump_pkg;

  // Formatter sequencer states, in emission order of one dump line.
  typedef enum logic [3:0] {
    IDLE,
    A2,
    A1,
    A0,
    COLON,
    SP0,
    FETCH,
    HI,
    LO,
    SP,
    CR,
    LF
  } dump_state_e;

  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  // Nibble to uppercase ASCII hex digit ('0'-'9', 'A'-'F').
  function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/sector_buf_ram.sv
// Simple dual-port sector buffer: one write port, one read port with a
// registered (1-cycle latency) read. Contents are never reset so the array
// maps onto block RAM.
module sector_buf_ram #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [2**AW];

  // Write port plus registered read port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/sector_hexdump_fmt.sv
// Captures one sector into a local buffer, then streams it out as an ASCII
// hex dump ("AAA: HH HH ... HH \r\n") over a wreq/wgnt character interface.
module sector_hexdump_fmt
  import sector_dump_pkg::*;
#(
  parameter int SECTOR_ASIZE    = 9,
  parameter int LINE_BYTES_LOG2 = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_en,
  input  logic [SECTOR_ASIZE-1:0] in_addr,
  input  logic [7:0]              in_byte,
  input  logic                    sector_done,
  output logic                    wreq,
  input  logic                    wgnt,
  output logic [7:0]              wdata,
  output logic                    busy,
  output logic                    dump_done,
  output logic                    overrun
);

  dump_state_e             state_q, state_d;
  logic [SECTOR_ASIZE-1:0] byte_ptr_q, byte_ptr_d;
  logic [SECTOR_ASIZE-1:0] ptr_inc;
  logic [7:0]              hold_q, hold_d;
  logic                    done_q, done_d;
  logic                    ovr_q, ovr_d;
  logic [7:0]              rd_data;
  logic [11:0]             line_addr;

  assign busy      = (state_q != IDLE);
  assign dump_done = done_q;
  assign overrun   = ovr_q;
  assign ptr_inc   = byte_ptr_q + 1'b1;
  // In the address states byte_ptr sits on a line boundary, so it already
  // equals {line_idx, LINE_BYTES_LOG2 zero bits}.
  assign line_addr = 12'(byte_ptr_q);

  // The read address follows the next-state pointer: the RAM registers the
  // byte on the edge entering FETCH, so it is valid during FETCH and can be
  // captured into hold_q on the edge leaving FETCH.
  sector_buf_ram #(
    .AW(SECTOR_ASIZE)
  ) u_buf (
    .clk     (clk),
    .we_i    (in_en & ~busy),
    .waddr_i (in_addr),
    .wdata_i (in_byte),
    .raddr_i (byte_ptr_d),
    .rdata_o (rd_data)
  );

  // State, pointer, holding byte and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      byte_ptr_q <= '0;
      hold_q     <= 8'h00;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_ptr_q <= byte_ptr_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
    end
  end

  // Overrun: set by any input activity while dumping, cleared on a new start.
  always_comb begin
    ovr_d = ovr_q;
    if (!busy && sector_done) begin
      ovr_d = 1'b0;
    end else if (busy && (in_en || sector_done)) begin
      ovr_d = 1'b1;
    end
  end

  // Next-state and character output; every emit state holds wreq/wdata
  // until the cycle wgnt is seen.
  always_comb begin
    state_d    = state_q;
    byte_ptr_d = byte_ptr_q;
    hold_d     = hold_q;
    done_d     = 1'b0;
    wreq       = 1'b0;
    wdata      = 8'h00;
    case (state_q)
      IDLE: begin
        if (sector_done) begin
          state_d = A2;
        end
      end
      A2: begin
        wreq  = 1'b1;
        wdata = hex2ascii(line_addr[11:8]);
        if (wgnt) state_d = A1;
      end
      A1: begin
        wreq  = 1'b1;
        wdata = hex2ascii(line_addr[7:4]);
        if (wgnt) state_d = A0;
      end
      A0: begin
        wreq  = 1'b1;
        wdata = hex2ascii(line_addr[3:0]);
        if (wgnt) state_d = COLON;
      end
      COLON: begin
        wreq  = 1'b1;
        wdata = CH_COLON;
        if (wgnt) state_d = SP0;
      end
      SP0: begin
        wreq  = 1'b1;
        wdata = CH_SP;
        if (wgnt) state_d = FETCH;
      end
      FETCH: begin
        hold_d  = rd_data;
        state_d = HI;
      end
      HI: begin
        wreq  = 1'b1;
        wdata = hex2ascii(hold_q[7:4]);
        if (wgnt) state_d = LO;
      end
      LO: begin
        wreq  = 1'b1;
        wdata = hex2ascii(hold_q[3:0]);
        if (wgnt) state_d = SP;
      end
      SP: begin
        wreq  = 1'b1;
        wdata = CH_SP;
        if (wgnt) begin
          byte_ptr_d = ptr_inc;
          if (ptr_inc[LINE_BYTES_LOG2-1:0] == '0) begin
            state_d = CR;
          end else begin
            state_d = FETCH;
          end
        end
      end
      CR: begin
        wreq  = 1'b1;
        wdata = CH_CR;
        if (wgnt) state_d = LF;
      end
      LF: begin
        wreq  = 1'b1;
        wdata = CH_LF;
        if (wgnt) begin
          // The pointer wrapping to zero marks the end of the sector.
          if (byte_ptr_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = A2;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
